// File: rtl/proc_control_unit.sv
// Moore control FSM sequencing the 16-bit datapath through fetch/decode/execute.
// Optional build macro CU_ILLEGAL_TRAP_EN: illegal opcodes trap to HALT and raise Illegal.
module proc_control_unit #(
  parameter int DATA_ADDR_W = 8,
  parameter int REG_ADDR_W  = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [15:0]            IR,
  output logic                   PC_Clr,
  output logic                   PC_Up,
  output logic                   IR_Ld,
  output logic [DATA_ADDR_W-1:0] D_Addr,
  output logic                   D_Wr,
  output logic                   RF_s,
  output logic [REG_ADDR_W-1:0]  RF_W_addr,
  output logic                   RF_W_en,
  output logic [REG_ADDR_W-1:0]  RF_Ra_addr,
  output logic [REG_ADDR_W-1:0]  RF_Rb_addr,
  output logic [2:0]             ALU_s0,
  output logic [3:0]             State,
  output logic [3:0]             NextState,
`ifdef CU_ILLEGAL_TRAP_EN
  output logic                   Illegal,
`endif
  output logic                   Halted
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  state_t state, state_nxt;
  logic   illegal_op;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = S_INIT;
    illegal_op = 1'b0;
    case (state)
      S_INIT:   state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (IR[15:12])
          OP_NOOP:  state_nxt = S_NOOP;
          OP_STORE: state_nxt = S_STORE;
          OP_LOAD:  state_nxt = S_LOAD_A;
          OP_ADD:   state_nxt = S_ADD;
          OP_SUB:   state_nxt = S_SUB;
          OP_HALT:  state_nxt = S_HALT;
          default: begin
            illegal_op = 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
            state_nxt  = S_HALT;
`else
            state_nxt  = S_NOOP;
`endif
          end
        endcase
      end
      S_LOAD_A: state_nxt = S_LOAD_B;
      S_LOAD_B, S_NOOP, S_STORE, S_ADD, S_SUB: state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_INIT;  // unreachable codes recover via INIT
    endcase
  end

`ifdef CU_ILLEGAL_TRAP_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                            Illegal <= 1'b0;
    else if (state == S_DECODE && illegal_op) Illegal <= 1'b1;
  end
`else
  logic unused_illegal;
  assign unused_illegal = illegal_op;
`endif

  assign State     = state;
  assign NextState = state_nxt;

  // Strobes depend on the state register alone, so an async reset kills any write at once.
  always_comb begin
    PC_Clr     = 1'b0;
    PC_Up      = 1'b0;
    IR_Ld      = 1'b0;
    D_Addr     = '0;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s0     = 3'b000;
    Halted     = 1'b0;
    case (state)
      S_INIT:  PC_Clr = 1'b1;
      S_FETCH: begin
        IR_Ld = 1'b1;
        PC_Up = 1'b1;
      end
      S_LOAD_A, S_LOAD_B: begin
        D_Addr    = IR[4 +: DATA_ADDR_W];
        RF_s      = 1'b1;
        RF_W_addr = IR[0 +: REG_ADDR_W];
        RF_W_en   = (state == S_LOAD_B);  // wait one cycle for memory read data
      end
      S_STORE: begin
        D_Addr     = IR[4 +: DATA_ADDR_W];
        RF_Ra_addr = IR[0 +: REG_ADDR_W];
        D_Wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = IR[8 +: REG_ADDR_W];
        RF_Rb_addr = IR[4 +: REG_ADDR_W];
        RF_W_addr  = IR[0 +: REG_ADDR_W];
        ALU_s0     = (state == S_ADD) ? 3'b001 : 3'b010;
        RF_W_en    = 1'b1;
      end
      S_HALT:  Halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_proc_control_unit.sv
// Directed table-driven bench for proc_control_unit plus reset/halt corner sequences.
module tb_proc_control_unit;

  logic        Clk, Reset;
  logic [15:0] IR;
  logic        PC_Clr, PC_Up, IR_Ld, D_Wr, RF_s, RF_W_en, Halted;
  logic [7:0]  D_Addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, State, NextState;
  logic [2:0]  ALU_s0;
  logic        ill;
  int          checks = 0;
  int          errors = 0;

  proc_control_unit #(.DATA_ADDR_W(8), .REG_ADDR_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .IR(IR),
    .PC_Clr(PC_Clr), .PC_Up(PC_Up), .IR_Ld(IR_Ld),
    .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s),
    .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
    .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
    .ALU_s0(ALU_s0), .State(State), .NextState(NextState),
`ifdef CU_ILLEGAL_TRAP_EN
    .Illegal(ill),
`endif
    .Halted(Halted)
  );

`ifndef CU_ILLEGAL_TRAP_EN
  assign ill = 1'b0;
`endif

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [29:0] act_outs;
  assign act_outs = {PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_addr,
                     RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0, Halted};

  function automatic logic [29:0] mk(input logic pcc, pcu, irl, input logic [7:0] da,
                                     input logic dw, rs, input logic [3:0] wa,
                                     input logic we, input logic [3:0] ra, rb,
                                     input logic [2:0] alu, input logic h);
    return {pcc, pcu, irl, da, dw, rs, wa, we, ra, rb, alu, h};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [15:0] ir);
    IR = ir;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic do_reset();
    #2 Reset = 1'b1;
    #1;
    chk("rst_async_state", {28'd0, State}, 32'd0);
    chk("rst_async_pcclr", {31'd0, PC_Clr}, 32'd1);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  typedef struct {
    logic [15:0] ir;
    logic [3:0]  st;
    logic [3:0]  nst;
    logic [29:0] outs;
  } vec_t;

  vec_t v[19];
  logic [29:0] o_fetch, o_zero, o_load_a, o_load_b;
  logic        trap;

  initial begin
`ifdef CU_ILLEGAL_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif
    o_fetch  = mk(0,1,1, 8'h00,0,0,4'h0,0,4'h0,4'h0,3'b000,0);
    o_zero   = '0;
    o_load_a = mk(0,0,0, 8'h1B,0,1,4'h3,0,4'h0,4'h0,3'b000,0);
    o_load_b = mk(0,0,0, 8'h1B,0,1,4'h3,1,4'h0,4'h0,3'b000,0);
    v[0]  = '{16'h21B3, 4'd1, 4'd2, o_fetch};
    v[1]  = '{16'h21B3, 4'd2, 4'd4, o_zero};
    v[2]  = '{16'h21B3, 4'd4, 4'd5, o_load_a};
    v[3]  = '{16'h21B3, 4'd5, 4'd1, o_load_b};
    v[4]  = '{16'h3123, 4'd1, 4'd2, o_fetch};
    v[5]  = '{16'h3123, 4'd2, 4'd7, o_zero};
    v[6]  = '{16'h3123, 4'd7, 4'd1, mk(0,0,0,8'h00,0,0,4'h3,1,4'h1,4'h2,3'b001,0)};
    v[7]  = '{16'h4456, 4'd1, 4'd2, o_fetch};
    v[8]  = '{16'h4456, 4'd2, 4'd8, o_zero};
    v[9]  = '{16'h4456, 4'd8, 4'd1, mk(0,0,0,8'h00,0,0,4'h6,1,4'h4,4'h5,3'b010,0)};
    v[10] = '{16'h1C05, 4'd1, 4'd2, o_fetch};
    v[11] = '{16'h1C05, 4'd2, 4'd6, o_zero};
    v[12] = '{16'h1C05, 4'd6, 4'd1, mk(0,0,0,8'hC0,1,0,4'h0,0,4'h5,4'h0,3'b000,0)};
    v[13] = '{16'h0000, 4'd1, 4'd2, o_fetch};
    v[14] = '{16'h0000, 4'd2, 4'd3, o_zero};
    v[15] = '{16'h0000, 4'd3, 4'd1, o_zero};
    v[16] = '{16'hF000, 4'd1, 4'd2, o_fetch};
    v[17] = '{16'hF000, 4'd2, trap ? 4'd9 : 4'd3, o_zero};
    v[18] = '{16'hF000, trap ? 4'd9 : 4'd3, trap ? 4'd9 : 4'd1,
              trap ? mk(0,0,0,8'h00,0,0,4'h0,0,4'h0,4'h0,3'b000,1) : o_zero};

    Reset = 1'b1;
    IR    = 16'h0000;
    @(negedge Clk);
    @(negedge Clk);
    chk("reset_state", {28'd0, State}, 32'd0);
    chk("reset_next",  {28'd0, NextState}, 32'd1);
    chk("reset_outs",  {2'd0, act_outs}, {2'd0, mk(1,0,0,8'h00,0,0,4'h0,0,4'h0,4'h0,3'b000,0)});
    chk("reset_ill",   {31'd0, ill}, 32'd0);
    Reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      step(v[i].ir);
      chk($sformatf("vec%0d_state", i), {28'd0, State}, {28'd0, v[i].st});
      chk($sformatf("vec%0d_next", i),  {28'd0, NextState}, {28'd0, v[i].nst});
      chk($sformatf("vec%0d_outs", i),  {2'd0, act_outs}, {2'd0, v[i].outs});
    end

    // Trap build holds HALT+Illegal; default build carries on to FETCH.
    if (trap) begin
      for (int i = 0; i < 10; i++) begin
        step(16'h1234 + 16'(i));
        chk("trap_hold_state", {28'd0, State}, 32'd9);
        chk("trap_hold_ill", {31'd0, ill}, 32'd1);
      end
    end else begin
      step(16'h5000);
      chk("after_noop_fetch", {28'd0, State}, 32'd1);
    end
    do_reset();
    chk("ill_cleared", {31'd0, ill}, 32'd0);

    // Reset release: FETCH then DECODE, then legal HALT held 10+ clocks.
    step(16'h5000);
    chk("post_rst_fetch", {28'd0, State}, 32'd1);
    chk("post_rst_irld", {30'd0, IR_Ld, PC_Up}, 32'd3);
    step(16'h5000);
    chk("post_rst_decode", {28'd0, State}, 32'd2);
    step(16'h5000);
    for (int i = 0; i < 12; i++) begin
      chk("halt_state", {28'd0, State}, 32'd9);
      chk("halt_flag", {31'd0, Halted}, 32'd1);
      chk("halt_no_ill", {31'd0, ill}, 32'd0);
      step(16'h2000 + 16'(i));
    end
    do_reset();
    chk("halt_cleared", {31'd0, Halted}, 32'd0);

    // Reset during LOAD_B drops RF_W_en without a clock edge.
    step(16'h21B3); step(16'h21B3); step(16'h21B3); step(16'h21B3);
    chk("loadb_state", {28'd0, State}, 32'd5);
    chk("loadb_wen", {31'd0, RF_W_en}, 32'd1);
    do_reset();
    chk("loadb_rst_wen", {31'd0, RF_W_en}, 32'd0);

    // Reset during STORE drops D_Wr without a clock edge.
    step(16'h1C05); step(16'h1C05); step(16'h1C05);
    chk("store_wr", {31'd0, D_Wr}, 32'd1);
    #2 Reset = 1'b1;
    #1;
    chk("store_rst_wr", {31'd0, D_Wr}, 32'd0);
    chk("store_rst_state", {28'd0, State}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
